// File: rtl/mac_dot_acc_if.sv
// mac_dot_acc stream/control bundle: start/len control,
// product input stream, dot-product result stream.
interface mac_dot_acc_if #(
  parameter int BWOP  = 32,
  parameter int BWACC = 40,
  parameter int LENW  = 8
);
  logic             start;
  logic [LENW-1:0]  cfg_len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [BWOP-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [BWACC-1:0] out_data;
  logic             out_ovf;

  modport master (
    output start, cfg_len,
    output in_valid, in_data,
    output out_ready,
    input  busy, in_ready,
    input  out_valid, out_data, out_ovf
  );

  modport slave (
    input  start, cfg_len,
    input  in_valid, in_data,
    input  out_ready,
    output busy, in_ready,
    output out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/mac_dot_acc.sv
// Dot-product accumulator: sums cfg_len products into a
// wide result. MAC_DOT_ACC_SAT_EN: saturate instead of wrap.
module mac_dot_acc #(
  parameter int BWOP  = 32,
  parameter int BWACC = 40,
  parameter int LENW  = 8
) (
  input logic clk,
  input logic rst,
  mac_dot_acc_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [BWACC-1:0] r_acc;
  logic [LENW-1:0]  r_cnt;
  logic             r_ovf;
  logic             w_xfer;
  logic             w_start;
  logic [BWACC:0]   w_sum;
  logic             w_last;

  assign w_start = (r_state == S_IDLE) & bus.start;
  assign w_xfer  = (r_state == S_ACC) & bus.in_valid;
  assign w_last  = (r_cnt == LENW'(1));
  assign w_sum   = {1'b0, r_acc}
                 + {{(BWACC-BWOP+1){1'b0}}, bus.in_data};

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.cfg_len != '0) w_next = S_ACC;
          else                   w_next = S_DONE;
        end
      end
      S_ACC: begin
        if (w_xfer && w_last) w_next = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Accumulator, remaining count and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_start) begin
      r_acc <= '0;
      r_cnt <= bus.cfg_len;
      r_ovf <= 1'b0;
    end else if (w_xfer) begin
      r_cnt <= r_cnt - LENW'(1);
      r_ovf <= r_ovf | w_sum[BWACC];
`ifdef MAC_DOT_ACC_SAT_EN
      // Once saturated, any further add carries again
      if (w_sum[BWACC]) r_acc <= '1;
      else              r_acc <= w_sum[BWACC-1:0];
`else
      r_acc <= w_sum[BWACC-1:0];
`endif
    end
  end

  assign bus.in_ready  = (r_state == S_ACC);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_data  = (r_state == S_DONE) ? r_acc : '0;
  assign bus.out_ovf   = (r_state == S_DONE) & r_ovf;

endmodule

// File: tb/tb_mac_dot_acc.sv
// Directed bench for mac_dot_acc: transaction-level sum
// model checked every cycle plus literal expectations.
module tb_mac_dot_acc;

  localparam int BWOP  = 32;
  localparam int BWACC = 40;
  localparam int LENW  = 8;
  localparam longint unsigned MAXV = (64'd1 << BWACC) - 64'd1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;
  bit   cmp_en = 1'b0;

  always #5 clk = ~clk;

  mac_dot_acc_if #(.BWOP(BWOP), .BWACC(BWACC), .LENW(LENW)) bi ();
  mac_dot_acc_if #(.BWOP(8), .BWACC(10), .LENW(4)) si ();

  mac_dot_acc #(.BWOP(BWOP), .BWACC(BWACC), .LENW(LENW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bi.slave)
  );

  mac_dot_acc #(.BWOP(8), .BWACC(10), .LENW(4)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (si.slave)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 collecting, 2 result pending.
  // Keeps the exact mathematical sum; wrap/sat applied on read.
  int              m_ph   = 0;
  int              m_left = 0;
  longint unsigned m_sum  = 0;

  function automatic logic [63:0] exp_data(longint unsigned s);
`ifdef MAC_DOT_ACC_SAT_EN
    return (s > MAXV) ? MAXV : s;
`else
    return s & MAXV;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ph = 0; m_left = 0; m_sum = 0;
    end else begin
      case (m_ph)
        0: if (bi.start) begin
             m_sum  = 0;
             m_left = int'(bi.cfg_len);
             m_ph   = (m_left == 0) ? 2 : 1;
           end
        1: if (bi.in_valid) begin
             m_sum  = m_sum + longint'(bi.in_data);
             m_left = m_left - 1;
             if (m_left == 0) m_ph = 2;
           end
        default: if (bi.out_ready) m_ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_in_ready", 64'(bi.in_ready), 64'(m_ph == 1));
      chk("m_out_valid", 64'(bi.out_valid), 64'(m_ph == 2));
      chk("m_busy", 64'(bi.busy), 64'(m_ph != 0));
      if (m_ph == 2) begin
        chk("m_out_data", 64'(bi.out_data), exp_data(m_sum));
        chk("m_out_ovf", 64'(bi.out_ovf), 64'(m_sum > MAXV));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bi.start = 0; bi.cfg_len = '0; bi.in_valid = 0;
    bi.in_data = '0; bi.out_ready = 0;
    si.start = 0; si.cfg_len = '0; si.in_valid = 0;
    si.in_data = '0; si.out_ready = 1;
    rst = 1;
    tick;
    cmp_en = 1'b1;
    tick;
    @(negedge clk);
    chk("rst_out_data", 64'(bi.out_data), 64'd0);
    chk("rst_out_ovf", 64'(bi.out_ovf), 64'd0);
    rst = 0;
    tick;

    // 1) 1+2+3+4 back to back
    bi.out_ready = 1; bi.start = 1; bi.cfg_len = 8'd4;
    tick;
    bi.start = 0;
    for (int i = 1; i <= 4; i++) begin
      bi.in_valid = 1; bi.in_data = 32'(i);
      tick;
    end
    bi.in_valid = 0;
    @(negedge clk);
    chk("t1_valid", 64'(bi.out_valid), 64'd1);
    chk("t1_data", 64'(bi.out_data), 64'd10);
    chk("t1_ovf", 64'(bi.out_ovf), 64'd0);
    tick;
    @(negedge clk);
    chk("t1_idle", 64'(bi.busy), 64'd0);

    // 2) zero-length vector
    bi.start = 1; bi.cfg_len = 8'd0;
    tick;
    bi.start = 0;
    @(negedge clk);
    chk("t2_valid", 64'(bi.out_valid), 64'd1);
    chk("t2_data", 64'(bi.out_data), 64'd0);
    chk("t2_in_ready", 64'(bi.in_ready), 64'd0);
    tick;

    // 3) gapped input, held result
    bi.out_ready = 0; bi.start = 1; bi.cfg_len = 8'd3;
    tick;
    bi.start = 0;
    for (int i = 0; i < 5; i++) begin
      bi.in_valid = (i % 2 == 0);
      bi.in_data = (i % 2 == 0) ? 32'(5 + i / 2) : 32'd77;
      tick;
    end
    bi.in_valid = 1; bi.in_data = 32'd99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_valid", 64'(bi.out_valid), 64'd1);
      chk("t3_data", 64'(bi.out_data), 64'd18);
      chk("t3_in_ready", 64'(bi.in_ready), 64'd0);
      tick;
    end
    bi.in_valid = 0;
    bi.out_ready = 1;
    tick;
    @(negedge clk);
    chk("t3_cleared", 64'(bi.out_valid), 64'd0);

    // 4) narrow instance overflow: 5 x 255 = 1275
    si.start = 1; si.cfg_len = 4'd5;
    tick;
    si.start = 0;
    for (int i = 0; i < 5; i++) begin
      si.in_valid = 1; si.in_data = 8'd255;
      tick;
    end
    si.in_valid = 0;
    @(negedge clk);
    chk("t4_valid", 64'(si.out_valid), 64'd1);
    chk("t4_ovf", 64'(si.out_ovf), 64'd1);
`ifdef MAC_DOT_ACC_SAT_EN
    chk("t4_data", 64'(si.out_data), 64'd1023);
`else
    chk("t4_data", 64'(si.out_data), 64'd251);
`endif
    tick;
    @(negedge clk);
    chk("t4_idle", 64'(si.busy), 64'd0);

    // 5) reset mid-vector discards partial sum
    bi.start = 1; bi.cfg_len = 8'd6;
    tick;
    bi.start = 0;
    for (int i = 1; i <= 3; i++) begin
      bi.in_valid = 1; bi.in_data = 32'(100 * i);
      tick;
    end
    bi.in_valid = 0;
    rst = 1;
    tick;
    rst = 0;
    @(negedge clk);
    chk("t5_in_ready", 64'(bi.in_ready), 64'd0);
    chk("t5_out_valid", 64'(bi.out_valid), 64'd0);
    chk("t5_busy", 64'(bi.busy), 64'd0);
    chk("t5_out_data", 64'(bi.out_data), 64'd0);
    chk("t5_out_ovf", 64'(bi.out_ovf), 64'd0);
    bi.start = 1; bi.cfg_len = 8'd2;
    tick;
    bi.start = 0;
    bi.in_valid = 1; bi.in_data = 32'd9;
    tick;
    bi.in_data = 32'd1;
    tick;
    bi.in_valid = 0;
    @(negedge clk);
    chk("t5_data", 64'(bi.out_data), 64'd10);
    tick;

    // 6) start ignored in ACC and DONE
    bi.out_ready = 0; bi.start = 1; bi.cfg_len = 8'd7;
    tick;
    bi.start = 0;
    for (int i = 1; i <= 7; i++) begin
      bi.in_valid = 1; bi.in_data = 32'(i);
      bi.start = (i == 3 || i == 4);
      bi.cfg_len = 8'd2;
      tick;
    end
    bi.in_valid = 0;
    bi.start = 1; bi.cfg_len = 8'd3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t6_valid", 64'(bi.out_valid), 64'd1);
      chk("t6_data", 64'(bi.out_data), 64'd28);
      tick;
    end
    bi.out_ready = 1;
    tick;
    bi.start = 0;
    @(negedge clk);
    chk("t6_busy", 64'(bi.busy), 64'd0);
    chk("t6_out_valid", 64'(bi.out_valid), 64'd0);
    tick;
    tick;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
